// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences shift/rotate requests through one shared barrel shifter
module shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [AMT_W-1:0]  req_amt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_err,
    output logic              busy,
    output logic [DATA_W-1:0] sh_a,
    output logic [AMT_W-1:0]  sh_amt,
    output logic [1:0]        sh_sel,
    input  logic [DATA_W-1:0] sh_result
);
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [1:0] SEL_SHL  = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHRA = 2'b10;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, acc_q, acc_d, res_q, res_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic                err_q, err_d;
    logic                is_rot, is_bad;

    assign is_rot      = (op_q == OP_ROL) || (op_q == OP_ROR);
    assign is_bad      = op_q > OP_ROR;
    assign req_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign resp_valid  = state_q == RESP;
    assign resp_result = res_q;
    assign resp_err    = err_q;

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            amt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            amt_q   <= amt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Next state and shifter drive; a rotate is two opposite shifts ORed together
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        amt_d   = amt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        err_d   = err_q;
        sh_a    = '0;
        sh_amt  = '0;
        sh_sel  = SEL_SHL;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    amt_d   = req_amt;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                sh_a   = a_q;
                sh_amt = amt_q;
                sh_sel = (op_q == OP_SHR || op_q == OP_ROR) ? SEL_SHR :
                         (op_q == OP_SHRA) ? SEL_SHRA : SEL_SHL;
                acc_d  = sh_result;
                if (is_bad) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (is_rot && amt_q != '0) begin
                    state_d = PASS2;
                end else begin
                    res_d   = sh_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            PASS2: begin
                sh_a    = a_q;
                sh_amt  = '0 - amt_q;
                sh_sel  = (op_q == OP_ROL) ? SEL_SHR : SEL_SHL;
                res_d   = acc_q | sh_result;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed tests with a cycle-level reference model of the sequencer
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
    logic [2:0]  req_op;
    logic [31:0] req_a, resp_result, sh_a, sh_result;
    logic [4:0]  req_amt, sh_amt;
    logic [1:0]  sh_sel;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_amt(req_amt), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result), .resp_err(resp_err),
        .busy(busy), .sh_a(sh_a), .sh_amt(sh_amt), .sh_sel(sh_sel), .sh_result(sh_result)
    );

    // The external shared shifter
    assign sh_result = (sh_sel == 2'b00) ? sh_a << sh_amt :
                       (sh_sel == 2'b01) ? sh_a >> sh_amt :
                       (sh_sel == 2'b10) ? $unsigned($signed(sh_a) >>> sh_amt) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt);
        logic [31:0] r = 32'h0;
        int n = int'(amt);
        for (int i = 0; i < 32; i++) begin
            case (op)
                3'd0: r[i] = (i >= n) ? a[i-n] : 1'b0;
                3'd1: r[i] = (i + n < 32) ? a[i+n] : 1'b0;
                3'd2: r[i] = (i + n < 32) ? a[i+n] : a[31];
                3'd3: r[(i+n)%32] = a[i];
                3'd4: r[i] = a[(i+n)%32];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_dir(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd4) ? 2'b01 : (op == 3'd2) ? 2'b10 : 2'b00;
    endfunction

    // Reference model: m_age counts cycles since acceptance, m_lat is the number of shifter passes
    int          m_age = 0, m_lat = 1;
    logic [2:0]  m_op = '0;
    logic [31:0] m_a = '0, m_res = '0;
    logic [4:0]  m_amt = '0;
    logic        m_err = 1'b0;
    bit          chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_age != 0));
            chk("req_ready", 32'(req_ready), 32'(m_age == 0));
            chk("resp_valid", 32'(resp_valid), 32'(m_age > m_lat));
            chk("resp_result", resp_result, m_res);
            chk("resp_err", 32'(resp_err), 32'(m_err));
            if (m_age == 1) begin
                chk("sh_a_p1", sh_a, m_a);
                chk("sh_amt_p1", 32'(sh_amt), 32'(m_amt));
                if (m_op <= 3'd4) chk("sh_sel_p1", 32'(sh_sel), 32'(ref_dir(m_op)));
            end else if (m_age == 2 && m_lat == 2) begin
                chk("sh_a_p2", sh_a, m_a);
                chk("sh_amt_p2", 32'(sh_amt), 32'((32 - int'(m_amt)) % 32));
                chk("sh_sel_p2", 32'(sh_sel), 32'(ref_dir(m_op) ^ 2'b01));
            end else begin
                chk("sh_quiet", {sh_a[29:0], sh_sel} | 32'(sh_amt), 32'h0);
            end
        end
        if (!rst_n) begin
            m_age = 0; m_res = '0; m_err = 1'b0; m_op = '0; m_a = '0; m_amt = '0;
            chk_en = 1'b1;
        end else if (m_age == 0) begin
            if (req_valid) begin
                m_op = req_op; m_a = req_a; m_amt = req_amt; m_age = 1;
                m_lat = ((req_op == 3'd3 || req_op == 3'd4) && req_amt != 0) ? 2 : 1;
            end
        end else if (m_age <= m_lat) begin
            m_age++;
            if (m_age > m_lat) begin
                m_err = m_op > 3'd4;
                m_res = m_err ? 32'h0 : ref_result(m_op, m_a, m_amt);
            end
        end else if (resp_ready) begin
            m_age = 0;
        end
    end

    logic [1:0] p1_sel, p2_sel;
    logic [4:0] p1_amt, p2_amt;

    // Issue one request from idle and check result, error flag and latency against literals
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt,
                       input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        int cyc = 0;
        req_op = op; req_a = a; req_amt = amt; req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = ~a; req_amt = amt + 5'd3;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin p1_sel = sh_sel; p1_amt = sh_amt; end
            if (cyc == 2) begin p2_sel = sh_sel; p2_amt = sh_amt; end
            if (resp_valid) break;
        end
        chk($sformatf("lat_op%0d", op), 32'(cyc), 32'(exp_lat));
        chk($sformatf("res_op%0d", op), resp_result, exp_res);
        chk($sformatf("err_op%0d", op), 32'(resp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; req_op = '0; req_a = '0; req_amt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_result", resp_result, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        @(posedge clk); #1;
        run(3'd0, 32'h0000_00F1, 5'd4, 32'h0000_0F10, 1'b0, 2);
        chk("shl_p1_sel", 32'(p1_sel), 32'h0);
        chk("shl_p1_amt", 32'(p1_amt), 32'd4);
        run(3'd2, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0, 2);
        run(3'd1, 32'h8000_0010, 5'd4, 32'h0800_0001, 1'b0, 2);
        run(3'd4, 32'h1234_5678, 5'd8, 32'h7812_3456, 1'b0, 3);
        chk("ror_p1_sel", 32'(p1_sel), 32'h1);
        chk("ror_p1_amt", 32'(p1_amt), 32'd8);
        chk("ror_p2_sel", 32'(p2_sel), 32'h0);
        chk("ror_p2_amt", 32'(p2_amt), 32'd24);
        run(3'd3, 32'h1234_5678, 5'd4, 32'h2345_6781, 1'b0, 3);
        chk("rol_p2_sel", 32'(p2_sel), 32'h1);
        run(3'd3, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 2);
        run(3'd7, 32'hDEAD_BEEF, 5'd3, 32'h0000_0000, 1'b1, 2);
        run(3'd4, 32'h8000_0001, 5'd31, 32'h0000_0003, 1'b0, 3);
        // Backpressure: response held while new requests wait
        resp_ready = 1'b0; req_op = 3'd0; req_a = 32'h1; req_amt = 5'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 3'd1; req_a = 32'h55; req_amt = 5'd2;
        repeat (2) @(negedge clk);
        chk("bp_valid", 32'(resp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", resp_result, 32'h2);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_busy", 32'(busy), 32'h1);
        cyc = 0;
        while (!resp_valid && cyc < 10) begin @(negedge clk); cyc++; end
        chk("bp_next_result", resp_result, 32'h15);
        @(posedge clk); #1;
        // Reset during the second pass of a rotate
        req_op = 3'd4; req_a = 32'h1234_5678; req_amt = 5'd8; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_amt", 32'(sh_amt), 32'd24);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_resp", 32'(resp_valid), 32'h0);
            @(negedge clk);
        end
        run(3'd0, 32'h8000_0001, 5'd31, 32'h8000_0000, 1'b0, 2);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that owns one shared 32-bit barrel shifter (logical left, logical right and arithmetic right units, selected by a mux outside this block).
It accepts shift/rotate requests over a valid/ready handshake and drives the shifter operand, amount and select lines.
Rotates are built from two shifter passes that are ORed together.
The result is returned over a valid/ready response channel and held until the consumer accepts it.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match the shifter.
AMT_W, 5, shift amount width, log2(DATA_W).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 illegal
req_a  input  DATA_W  operand
req_amt  input  AMT_W  shift/rotate amount
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_result  output  DATA_W  result
resp_err  output  1  request had an illegal opcode
busy  output  1  high whenever state != IDLE
sh_a  output  DATA_W  shifter operand
sh_amt  output  AMT_W  shifter amount
sh_sel  output  2  shifter select: 00 shl, 01 shr, 10 shra
sh_result  input  DATA_W  combinational shifter output, valid in the same cycle

Behaviour:
- FSM states: IDLE, PASS1, PASS2, RESP. All registers update on the rising clk edge.
- Reset: rst_n low at a clk edge forces:
  - state IDLE; resp_valid 0, resp_result 0, resp_err 0, busy 0;
  - latched op/a/amt and accumulator cleared to 0.
  - Reset aborts any in-flight operation; no response is produced.
  - req_ready is 1 in the first cycle after reset release.
- req_ready = (state == IDLE). busy = (state != IDLE). Only one operation is in flight; there is no request queue.
- IDLE: when req_valid && req_ready at an edge, latch req_op, req_a and req_amt, then go to PASS1.
- PASS1:
  - Drive sh_a = latched a and sh_amt = latched amt.
  - sh_sel: SHL and ROL use 00; SHR and ROR use 01; SHRA uses 10.
  - Capture sh_result into the accumulator at the edge.
  - Non-rotate op, or rotate with amt == 0: go to RESP; resp_result = sh_result; resp_err = 0.
  - Rotate with amt != 0: go to PASS2.
  - Illegal op: do not use the shifter result; resp_result = 0; resp_err = 1; go to RESP.
- PASS2 (rotates only):
  - Drive sh_a = latched a and sh_amt = (0 - amt) mod 32, which lies in 1..31.
  - sh_sel is the opposite direction: ROL uses 01, ROR uses 00.
  - resp_result = accumulator | sh_result; resp_err = 0; go to RESP.
- RESP:
  - resp_valid = 1; resp_result and resp_err stay stable.
  - Any req_valid is ignored (req_ready = 0).
  - On resp_valid && resp_ready at an edge: go to IDLE and clear resp_valid.
- Shifter outputs in IDLE and RESP: sh_a = 0, sh_amt = 0, sh_sel = 00. This keeps the shared shifter quiet and deterministic.
- Latency, with request accepted at edge T:
  - resp_valid is high from cycle T+2 for non-rotates, rotate with amt 0, and illegal ops;
  - from cycle T+3 for rotates with amt != 0.
- Throughput: the earliest next accept is the edge after the response handshake. Minimum issue interval is 3 cycles, or 4 for rotates.
- Changes to req_a/req_amt after acceptance have no effect, because all operands are latched.
- Arithmetic is modulo 32 on amounts. The OR of two disjoint shifted fields gives an exact rotate.

Test Plan:
- SHL, a=0x000000F1, amt=4 -> resp_result 0x00000F10, resp_err 0, resp_valid at T+2. sh_sel=00 and sh_amt=4 during PASS1.
- SHRA, a=0x80000010, amt=4 -> 0xF8000001. SHR with the same operands -> 0x08000001. Both at T+2.
- ROR, a=0x12345678, amt=8 -> 0x78123456 at T+3, with sh_sel/sh_amt of 01/8 in PASS1 then 00/24 in PASS2. ROL, same a, amt=4 -> 0x23456781.
- ROL, a=0x12345678, amt=0 -> 0x12345678 at T+2, with a single shifter pass and no PASS2.
- Backpressure: hold resp_ready=0 for 5 cycles while req_valid=1 with new operands.
  - resp_result must stay stable and req_ready must stay 0.
  - Raise resp_ready: handshake, then the next request is accepted the following cycle.
- Illegal op 3'b111 -> resp_result 0x00000000, resp_err 1 at T+2.
- Drive rst_n low for one cycle during PASS2 of a ROR -> resp_valid never rises, busy=0, req_ready=1 on the next cycle.
